move_input: RTL and testbench



---
 rtl/move_input_if.sv | 27 ++
 rtl/move_input.sv | 119 +++++++++++
 tb/tb_move_input.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/move_input_if.sv
// Button-to-move bundle: raw buttons in, one-hot move pulses,
// conflict flag, held level and accepted-move count out.
interface move_input_if #(
  parameter int CNT_W = 8
);
  logic             btn_n;
  logic             btn_s;
  logic             btn_e;
  logic             btn_w;
  logic             n;
  logic             s;
  logic             e;
  logic             w;
  logic             conflict;
  logic             held;
  logic [CNT_W-1:0] move_cnt;

  modport master (
    input  btn_n, btn_s, btn_e, btn_w,
    output n, s, e, w, conflict, held, move_cnt
  );

  modport slave (
    output btn_n, btn_s, btn_e, btn_w,
    input  n, s, e, w, conflict, held, move_cnt
  );
endinterface

// File: rtl/move_input.sv
// Raw direction buttons -> clean one-hot move pulses for the room FSM.
// Define MOVE_INPUT_DEBOUNCE_EN to build the per-button debouncers.
module move_input #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input logic         clock,
  input logic         R,
  move_input_if.master io
);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;

  assign raw = {io.btn_w, io.btn_e, io.btn_s, io.btn_n};

  // Reset loads "pressed" so a button held through reset never moves.
  always_ff @(posedge clock) begin
    if (R) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef MOVE_INPUT_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic          d_q;
    logic [CW-1:0] c_q;

    always_ff @(posedge clock) begin
      if (R) begin
        d_q <= 1'b1;
        c_q <= '0;
      end else if (sync2[g] == d_q) begin
        c_q <= '0;
      end else if (c_q == CMAX) begin
        d_q <= sync2[g];
        c_q <= '0;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end

    assign deb[g] = d_q;
  end
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign deb = sync2;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       pulse_q;
  logic [3:0]       pulse_d;
  logic             conf_q;
  logic             conf_d;
  logic             inc;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    conf_d  = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (deb == 4'b0): state_d = IDLE;
          $onehot(deb): begin
            state_d = HELD;
            pulse_d = deb;
            inc     = 1'b1;
          end
          default: begin
            state_d = HELD;
            conf_d  = 1'b1;
          end
        endcase
      end
      HELD: begin
        if (deb == 4'b0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (R) begin
      state_q <= HELD;
      pulse_q <= '0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      conf_q  <= conf_d;
      if (inc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign io.n        = pulse_q[0];
  assign io.s        = pulse_q[1];
  assign io.e        = pulse_q[2];
  assign io.w        = pulse_q[3];
  assign io.conflict = conf_q;
  assign io.held     = (state_q == HELD);
  assign io.move_cnt = cnt_q;

endmodule

// File: tb/tb_move_input.sv
// Scoreboard bench for move_input: history-based button model predicts
// pulses, held level and move count; a negedge monitor checks them.
module tb_move_input;

  localparam int DEB  = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef MOVE_INPUT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       R     = 1'b1;
  logic [3:0] btn   = 4'b0;

  always #5 clock = ~clock;

  move_input_if #(.CNT_W(CW)) io ();

  assign io.btn_n = btn[0];
  assign io.btn_s = btn[1];
  assign io.btn_e = btn[2];
  assign io.btn_w = btn[3];

  move_input #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CW)
  ) dut (
    .clock(clock),
    .R    (R),
    .io   (io)
  );

  typedef struct {
    int       cyc;
    logic [4:0] kind;
    int       cnt;
  } ev_t;

  typedef struct {
    bit held;
    int cnt;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  int compared   = 0;
  int mismatched = 0;
  int ecount     = 0;

  // Reference model: buttons pass two delay slots, then a level is
  // accepted once the last DEB samples all agree on a new value.
  logic [3:0] m_s1, m_s2, m_deb;
  logic [3:0] hist[$];
  bit         m_held;
  int         m_cnt;

  always @(posedge clock) begin
    logic [3:0] d_use;
    bit         all_eq;
    ecount++;
    if (R) begin
      m_s1   = '1;
      m_s2   = '1;
      m_deb  = '1;
      hist.delete();
      m_held = 1'b1;
      m_cnt  = 0;
    end else begin
      d_use = DEB_EN ? m_deb : m_s2;
      if (m_held) begin
        if (d_use == 4'b0) m_held = 1'b0;
      end else if (d_use != 4'b0) begin
        m_held = 1'b1;
        if ($countones(d_use) == 1) begin
          m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
          evq.push_back('{ecount, {1'b0, d_use}, m_cnt});
        end else begin
          evq.push_back('{ecount, 5'b10000, m_cnt});
        end
      end
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        for (int b = 0; b < 4; b++) begin
          all_eq = 1'b1;
          foreach (hist[k]) if (hist[k][b] != m_s2[b]) all_eq = 1'b0;
          if (all_eq && (m_s2[b] != m_deb[b])) m_deb[b] = m_s2[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    stq.push_back('{m_held, m_cnt});
  end

  always @(negedge clock) begin
    logic [4:0]    act;
    logic [CW-1:0] exp_cnt;
    st_t           st;
    ev_t           ev;
    act = {io.conflict, io.w, io.e, io.s, io.n};
    if (stq.size() > 0) begin
      st = stq.pop_front();
      exp_cnt = CW'(st.cnt);
      compared++;
      if (io.held !== st.held) begin
        mismatched++;
        $display("FAIL held @%0d: got %b want %b", ecount, io.held, st.held);
      end
      compared++;
      if (io.move_cnt !== exp_cnt) begin
        mismatched++;
        $display("FAIL move_cnt @%0d: got %0d want %0d",
                 ecount, io.move_cnt, exp_cnt);
      end
    end
    if (evq.size() > 0 && evq[0].cyc == ecount) begin
      ev = evq.pop_front();
      compared++;
      if (act !== ev.kind) begin
        mismatched++;
        $display("FAIL pulse @%0d: got cnwesn=%b want %b",
                 ecount, act, ev.kind);
      end
    end else if (act !== 5'b0) begin
      compared++;
      mismatched++;
      $display("FAIL spurious pulse @%0d: got %b want 00000", ecount, act);
    end else if (evq.size() > 0 && evq[0].cyc < ecount) begin
      ev = evq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missed pulse @%0d: got 00000 want %b", ev.cyc, ev.kind);
    end
  end

  task automatic hold(input logic [3:0] v, input int n);
    btn = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    R = 1'b1;
    repeat (n) @(negedge clock);
    R = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    int         r;
    do_reset(3);
    hold(4'b0000, 15);
    hold(4'b0100, 20);
    hold(4'b0000, 15);
    hold(4'b0010, 3);
    hold(4'b0000, 1);
    hold(4'b0010, 2);
    hold(4'b0000, 15);
    hold(4'b1001, 20);
    hold(4'b0000, 15);
    hold(4'b0001, 15);
    do_reset(2);
    hold(4'b0001, 20);
    hold(4'b0000, 15);
    hold(4'b0001, 15);
    hold(4'b0000, 15);
    do_reset(2);
    hold(4'b0000, 15);
    for (int i = 0; i < 5; i++) begin
      hold(4'(1 << (i % 4)), 12);
      hold(4'b0000, 12);
    end
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      v = 4'(1 << $urandom_range(0, 3));
      else if (r < 8) v = 4'b0;
      else            v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3));
      hold(v, $urandom_range(1, 14));
    end
    hold(4'b0000, 30);
    compared++;
    if (evq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending events want 0", evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
